chip8_video: RTL and testbench

//  Holds the 64x32 monochrome CHIP-8 framebuffer and executes the two display

---
 rtl/chip8_video_if.sv | 42 ++++
 rtl/chip8_video.sv | 169 ++++++++++++++++
 tb/tb_chip8_video.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/chip8_video_if.sv
//==============================================================================
// Interface : chip8_video_if
// Purpose   : Command, sprite-memory and pixel-read signals of chip8_video
// Revision  : 1.0
//==============================================================================
`default_nettype none

interface chip8_video_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  cls_valid_in;
  logic                  draw_valid_in;
  logic [7:0]            draw_x_in;
  logic [7:0]            draw_y_in;
  logic [3:0]            draw_n_in;
  logic [ADDR_WIDTH-1:0] sprite_addr_in;
  logic                  ready_out;
  logic                  done_out;
  logic                  collision_out;
  logic                  mem_rd_out;
  logic [ADDR_WIDTH-1:0] mem_addr_out;
  logic [7:0]            mem_data_in;
  logic [5:0]            chip8_x_in;
  logic [4:0]            chip8_y_in;
  logic                  chip8_pixel_out;

  modport slave (
    input  cls_valid_in, draw_valid_in, draw_x_in, draw_y_in, draw_n_in,
           sprite_addr_in, mem_data_in, chip8_x_in, chip8_y_in,
    output ready_out, done_out, collision_out, mem_rd_out, mem_addr_out,
           chip8_pixel_out
  );

  modport master (
    output cls_valid_in, draw_valid_in, draw_x_in, draw_y_in, draw_n_in,
           sprite_addr_in, mem_data_in, chip8_x_in, chip8_y_in,
    input  ready_out, done_out, collision_out, mem_rd_out, mem_addr_out,
           chip8_pixel_out
  );
endinterface

`default_nettype wire

// File: rtl/chip8_video.sv
//==============================================================================
// Module   : chip8_video
// Purpose  : 64x32 CHIP-8 framebuffer executing CLS and DRW, with pixel read port
// Revision : 1.0
//==============================================================================
`default_nettype none

module chip8_video #(
  parameter bit CLIP_SPRITES = 1'b1,
  parameter int ADDR_WIDTH   = 12
) (
  input  logic          clk_in,
  input  logic          rst_in,
  chip8_video_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FETCH = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state_q;
  logic [63:0]           fb_q [32];
  logic [4:0]            row_q;
  logic [5:0]            x_q;
  logic [4:0]            y_q;
  logic [3:0]            n_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  coll_acc_q;

  logic                  ready_q;
  logic                  done_q;
  logic                  coll_q;
  logic                  mem_rd_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  pixel_q;

  logic [63:0]           mask_d;
  logic [5:0]            tgt_sum_d;
  logic [4:0]            tgt_row_d;
  logic                  tgt_skip_d;
  logic                  hit_d;
  logic                  last_row_d;
  logic                  unused_hi_bits;

  assign unused_hi_bits = ^{bus.draw_x_in[7:6], bus.draw_y_in[7:5]};

  // Sprite byte spread across columns x..x+7, MSB leftmost; overflow columns clip or wrap
  always_comb begin
    mask_d = '0;
    for (int b = 0; b < 8; b++) begin
      if (!(CLIP_SPRITES && (({1'b0, x_q} + 7'(b)) > 7'd63))) begin
        mask_d[x_q + 6'(b)] = mask_d[x_q + 6'(b)] | bus.mem_data_in[3'(7 - b)];
      end
    end
  end

  assign tgt_sum_d  = 6'(y_q) + 6'(row_q);
  assign tgt_skip_d = CLIP_SPRITES && tgt_sum_d[5];
  assign tgt_row_d  = tgt_sum_d[4:0];
  assign hit_d      = !tgt_skip_d && (|(fb_q[tgt_row_d] & mask_d));
  assign last_row_d = (row_q + 5'd1) == {1'b0, n_q};

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      n_q        <= '0;
      addr_q     <= '0;
      coll_acc_q <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      coll_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      pixel_q    <= 1'b0;
      for (int r = 0; r < 32; r++) begin
        fb_q[r] <= '0;
      end
    end else begin
      pixel_q  <= fb_q[bus.chip8_y_in][bus.chip8_x_in];
      done_q   <= 1'b0;
      mem_rd_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (bus.cls_valid_in) begin
            state_q <= S_CLEAR;
            row_q   <= '0;
            ready_q <= 1'b0;
          end else if (bus.draw_valid_in) begin
            x_q        <= bus.draw_x_in[5:0];
            y_q        <= bus.draw_y_in[4:0];
            n_q        <= bus.draw_n_in;
            addr_q     <= bus.sprite_addr_in;
            row_q      <= '0;
            coll_acc_q <= 1'b0;
            ready_q    <= 1'b0;
            if (bus.draw_n_in == 4'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              coll_q  <= 1'b0;
            end else begin
              state_q    <= S_FETCH;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= bus.sprite_addr_in;
            end
          end
        end

        S_CLEAR: begin
          fb_q[row_q] <= '0;
          if (row_q == 5'd31) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            row_q <= row_q + 5'd1;
          end
        end

        S_FETCH: begin
          state_q <= S_WAIT;
        end

        S_WAIT: begin
          if (!tgt_skip_d) begin
            fb_q[tgt_row_d] <= fb_q[tgt_row_d] ^ mask_d;
          end
          coll_acc_q <= coll_acc_q | hit_d;
          if (last_row_d) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            coll_q  <= coll_acc_q | hit_d;
          end else begin
            state_q    <= S_FETCH;
            row_q      <= row_q + 5'd1;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= addr_q + ADDR_WIDTH'(row_q + 5'd1);
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end

        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready_out       = ready_q;
  assign bus.done_out        = done_q;
  assign bus.collision_out   = coll_q;
  assign bus.mem_rd_out      = mem_rd_q;
  assign bus.mem_addr_out    = mem_addr_q;
  assign bus.chip8_pixel_out = pixel_q;

endmodule

`default_nettype wire

// File: tb/tb_chip8_video.sv
//==============================================================================
// Module   : tb_chip8_video
// Purpose  : Directed bench for chip8_video, clipping and wrapping instances side by side
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_chip8_video;

  logic clk;
  logic rst_n;

  chip8_video_if #(.ADDR_WIDTH(12)) a_if ();
  chip8_video_if #(.ADDR_WIDTH(12)) b_if ();

  chip8_video #(.CLIP_SPRITES(1'b1), .ADDR_WIDTH(12)) u_clip (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (a_if.slave)
  );

  chip8_video #(.CLIP_SPRITES(1'b0), .ADDR_WIDTH(12)) u_wrap (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mem [4096];
  logic [11:0] addr_log [16];
  int          rd_cnt = 0;

  // Sprite memory answers one cycle after the read strobe
  always @(posedge clk) begin
    a_if.mem_data_in <= a_if.mem_rd_out ? mem[a_if.mem_addr_out] : 8'h00;
    b_if.mem_data_in <= b_if.mem_rd_out ? mem[b_if.mem_addr_out] : 8'h00;
    if (a_if.mem_rd_out) begin
      addr_log[rd_cnt % 16] <= a_if.mem_addr_out;
      rd_cnt                <= rd_cnt + 1;
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_cmd(input logic cls, input logic drw, input logic [7:0] x,
                         input logic [7:0] y, input logic [3:0] n, input logic [11:0] addr);
    a_if.cls_valid_in = cls;  b_if.cls_valid_in = cls;
    a_if.draw_valid_in = drw; b_if.draw_valid_in = drw;
    a_if.draw_x_in = x;       b_if.draw_x_in = x;
    a_if.draw_y_in = y;       b_if.draw_y_in = y;
    a_if.draw_n_in = n;       b_if.draw_n_in = n;
    a_if.sprite_addr_in = addr; b_if.sprite_addr_in = addr;
  endtask

  // Issues one command; lat = edges from the accept edge (inclusive) to done_out, -1 on timeout
  task automatic do_cmd(input logic cls, input logic drw, input logic [7:0] x, input logic [7:0] y,
                        input logic [3:0] n, input logic [11:0] addr, output int lat, output logic done_b);
    lat = -1;
    done_b = 1'b0;
    set_cmd(cls, drw, x, y, n, addr);
    @(posedge clk); #1;
    set_cmd(1'b0, 1'b0, 8'd0, 8'd0, 4'd0, 12'd0);
    for (int k = 1; k <= 60; k++) begin
      if (a_if.done_out) begin
        lat = k;
        done_b = b_if.done_out;
        break;
      end
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic read_px(input int x, input int y, output logic pa, output logic pb);
    a_if.chip8_x_in = 6'(x); b_if.chip8_x_in = 6'(x);
    a_if.chip8_y_in = 5'(y); b_if.chip8_y_in = 5'(y);
    @(posedge clk); #1;
    pa = a_if.chip8_pixel_out;
    pb = b_if.chip8_pixel_out;
  endtask

  task automatic scan(output int ca, output int cb);
    logic pa, pb;
    ca = 0;
    cb = 0;
    for (int y = 0; y < 32; y++) begin
      for (int x = 0; x < 64; x++) begin
        read_px(x, y, pa, pb);
        ca += int'(pa);
        cb += int'(pb);
      end
    end
  endtask

  typedef struct {
    int   x;
    int   y;
    logic exp_a;
    logic exp_b;
  } px_vec_t;

  px_vec_t font_vec [11];
  px_vec_t clip_vec [10];

  initial begin
    int   lat, ca, cb, base, dcnt;
    logic db, pa, pb;

    font_vec = '{'{0,0,1,1}, '{1,0,1,1}, '{2,0,1,1}, '{3,0,1,1}, '{4,0,0,0},
                 '{0,1,1,1}, '{1,1,0,0}, '{3,1,1,1}, '{0,4,1,1}, '{3,4,1,1}, '{0,5,0,0}};
    clip_vec = '{'{60,30,1,1}, '{63,31,1,1}, '{59,30,0,0}, '{0,30,0,1}, '{3,31,0,1},
                 '{4,30,0,0}, '{60,0,0,1}, '{0,0,0,1}, '{63,0,0,1}, '{60,1,0,0}};

    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h050] = 8'hF0; mem[12'h051] = 8'h90; mem[12'h052] = 8'h90;
    mem[12'h053] = 8'h90; mem[12'h054] = 8'hF0;
    mem[12'h100] = 8'hFF; mem[12'h101] = 8'hFF; mem[12'h102] = 8'hFF;
    for (int i = 0; i < 10; i++) mem[12'h200 + i] = 8'hAA;

    rst_n = 1'b0;
    set_cmd(1'b0, 1'b0, 8'd0, 8'd0, 4'd0, 12'd0);
    a_if.chip8_x_in = '0; b_if.chip8_x_in = '0;
    a_if.chip8_y_in = '0; b_if.chip8_y_in = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state and empty framebuffer
    check("reset_ready", a_if.ready_out, 1);
    check("reset_ready_b", b_if.ready_out, 1);
    check("reset_collision", a_if.collision_out, 0);
    check("reset_done", a_if.done_out, 0);
    check("reset_mem_rd", a_if.mem_rd_out, 0);
    check("reset_mem_addr", a_if.mem_addr_out, 0);
    scan(ca, cb);
    check("reset_fb_a", ca, 0);
    check("reset_fb_b", cb, 0);

    // Font '0' at origin
    base = rd_cnt;
    do_cmd(1'b0, 1'b1, 8'd0, 8'd0, 4'd5, 12'h050, lat, db);
    check("font_latency", lat, 11);
    check("font_done_b", db, 1);
    check("font_collision_a", a_if.collision_out, 0);
    check("font_collision_b", b_if.collision_out, 0);
    check("font_reads", rd_cnt - base, 5);
    for (int j = 0; j < 5; j++) check($sformatf("font_addr%0d", j), addr_log[(base + j) % 16], 12'h050 + j);
    for (int i = 0; i < 11; i++) begin
      read_px(font_vec[i].x, font_vec[i].y, pa, pb);
      check($sformatf("font_px_a(%0d,%0d)", font_vec[i].x, font_vec[i].y), pa, font_vec[i].exp_a);
      check($sformatf("font_px_b(%0d,%0d)", font_vec[i].x, font_vec[i].y), pb, font_vec[i].exp_b);
    end
    scan(ca, cb);
    check("font_count_a", ca, 14);
    check("font_count_b", cb, 14);

    // Same sprite again erases it and reports collision
    do_cmd(1'b0, 1'b1, 8'd0, 8'd0, 4'd5, 12'h050, lat, db);
    check("redraw_latency", lat, 11);
    check("redraw_collision_a", a_if.collision_out, 1);
    check("redraw_collision_b", b_if.collision_out, 1);
    scan(ca, cb);
    check("redraw_count_a", ca, 0);
    check("redraw_count_b", cb, 0);

    // Zero-height sprite: one cycle, clears collision, no memory reads
    base = rd_cnt;
    do_cmd(1'b0, 1'b1, 8'd10, 8'd10, 4'd0, 12'h050, lat, db);
    check("n0_latency", lat, 1);
    check("n0_collision", a_if.collision_out, 0);
    check("n0_reads", rd_cnt - base, 0);

    // Corner sprite: clipped on u_clip, wrapped on u_wrap
    do_cmd(1'b0, 1'b1, 8'd60, 8'd30, 4'd3, 12'h100, lat, db);
    check("corner_latency", lat, 7);
    check("corner_collision_b", b_if.collision_out, 0);
    for (int i = 0; i < 10; i++) begin
      read_px(clip_vec[i].x, clip_vec[i].y, pa, pb);
      check($sformatf("corner_px_a(%0d,%0d)", clip_vec[i].x, clip_vec[i].y), pa, clip_vec[i].exp_a);
      check($sformatf("corner_px_b(%0d,%0d)", clip_vec[i].x, clip_vec[i].y), pb, clip_vec[i].exp_b);
    end
    scan(ca, cb);
    check("corner_count_a", ca, 8);
    check("corner_count_b", cb, 24);

    do_cmd(1'b1, 1'b0, 8'd0, 8'd0, 4'd0, 12'd0, lat, db);
    check("cls_latency", lat, 33);
    scan(ca, cb);
    check("cls_count_a", ca, 0);
    check("cls_count_b", cb, 0);

    // Vx/Vy taken modulo 64/32
    do_cmd(1'b0, 1'b1, 8'h44, 8'h21, 4'd1, 12'h100, lat, db);
    check("mod_latency", lat, 3);
    read_px(3, 1, pa, pb);  check("mod_px(3,1)", {pa, pb}, 2'b00);
    read_px(4, 1, pa, pb);  check("mod_px(4,1)", {pa, pb}, 2'b11);
    read_px(11, 1, pa, pb); check("mod_px(11,1)", {pa, pb}, 2'b11);
    read_px(12, 1, pa, pb); check("mod_px(12,1)", {pa, pb}, 2'b00);

    // CLS and DRW together: CLS wins
    do_cmd(1'b1, 1'b1, 8'd0, 8'd0, 4'd5, 12'h050, lat, db);
    check("both_latency", lat, 33);
    scan(ca, cb);
    check("both_count_a", ca, 0);
    check("both_count_b", cb, 0);

    // DRW pulsed while CLS is busy is dropped
    base = rd_cnt;
    set_cmd(1'b1, 1'b0, 8'd0, 8'd0, 4'd0, 12'd0);
    @(posedge clk); #1;
    set_cmd(1'b0, 1'b0, 8'd0, 8'd0, 4'd0, 12'd0);
    repeat (4) @(posedge clk);
    #1;
    check("busy_ready", a_if.ready_out, 0);
    set_cmd(1'b0, 1'b1, 8'd0, 8'd0, 4'd1, 12'h100);
    @(posedge clk); #1;
    set_cmd(1'b0, 1'b0, 8'd0, 8'd0, 4'd0, 12'd0);
    dcnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (a_if.done_out) dcnt++;
    end
    check("busy_done_pulses", dcnt, 1);
    check("busy_reads", rd_cnt - base, 0);
    scan(ca, cb);
    check("busy_count_a", ca, 0);

    // Reset in the middle of a 10-row draw
    do_cmd(1'b0, 1'b1, 8'd0, 8'd0, 4'd1, 12'h100, lat, db);
    check("pre_reset_latency", lat, 3);
    set_cmd(1'b0, 1'b1, 8'd8, 8'd4, 4'd10, 12'h200);
    @(posedge clk); #1;
    set_cmd(1'b0, 1'b0, 8'd0, 8'd0, 4'd0, 12'd0);
    for (int k = 0; k < 10 && !a_if.mem_rd_out; k++) begin
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
    check("abort_in_fetch", a_if.mem_rd_out, 1);
    rst_n = 1'b0;
    #1;
    check("abort_ready", a_if.ready_out, 1);
    check("abort_mem_rd", a_if.mem_rd_out, 0);
    check("abort_mem_addr", a_if.mem_addr_out, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (a_if.done_out || b_if.done_out) dcnt++;
    end
    check("abort_no_done", dcnt, 0);
    scan(ca, cb);
    check("abort_count_a", ca, 0);
    check("abort_count_b", cb, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
